// File: rtl/llc_update_queue_pkg.sv
// Shared LLC types and constants for the update queue and its packet FIFO.
package llc_update_queue_pkg;

  localparam int unsigned LLC_SETS   = 512;
  localparam int unsigned LLC_WAYS   = 16;
  localparam int unsigned LLC_SET_W  = $clog2(LLC_SETS);
  localparam int unsigned LLC_WAY_W  = $clog2(LLC_WAYS);
  localparam int unsigned LLC_TAG_W  = 16;
  localparam int unsigned LLC_LINE_W = 32;
  localparam int unsigned LLC_OWN_W  = 4;
  localparam int unsigned LLC_SHR_W  = 16;

  typedef logic [LLC_SET_W-1:0] llc_set_t;
  typedef logic [LLC_WAY_W-1:0] llc_way_t;
  typedef logic [2:0]           llc_state_t;
  typedef logic                 llc_hprot_t;

  localparam llc_state_t INVALID = 3'd0;
  localparam llc_state_t VALID   = 3'd1;
  localparam llc_hprot_t DATA    = 1'b1;

  typedef enum logic [1:0] {
    UPD_WRITE = 2'd0,
    UPD_RST   = 2'd1,
    UPD_FLUSH = 2'd2
  } llc_upd_op_t;

  typedef struct packed {
    logic [LLC_TAG_W-1:0]  tag;
    llc_state_t            state;
    logic [LLC_LINE_W-1:0] line;
    llc_hprot_t            hprot;
    logic [LLC_OWN_W-1:0]  owner;
    logic [LLC_SHR_W-1:0]  sharers;
    logic                  dirty;
  } llc_entry_t;

  typedef struct packed {
    llc_upd_op_t op;
    llc_set_t    set;
    llc_way_t    way;
    llc_entry_t  entry;
    llc_way_t    evict_way;
    logic        upd_evict;
  } llc_upd_pkt_t;

  typedef enum logic [2:0] {
    IDLE,
    RST_SWEEP,
    FLUSH_RD,
    FLUSH_WR,
    DONE
  } llc_upd_state_t;

  // A flush only invalidates valid lines that hold data (not instructions).
  function automatic logic is_flushable(input llc_state_t state, input llc_hprot_t hprot);
    return (state == VALID) && (hprot == DATA);
  endfunction

endpackage

// File: rtl/llc_update_fifo.sv
// Circular packet FIFO with extra pointer MSB for full/empty, plus a
// per-entry view of queued writes for the same-set hazard compare.
module llc_update_fifo
  import llc_update_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SET_W = LLC_SET_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  llc_upd_pkt_t     push_pkt,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output llc_upd_pkt_t     head,
  output logic [DEPTH-1:0] ent_write,
  output logic [SET_W-1:0] ent_set [DEPTH]
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   wr_ptr;
  logic [IDX_W:0]   rd_ptr;
  logic [IDX_W:0]   count;
  logic [IDX_W-1:0] offs;
  llc_upd_pkt_t     mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[IDX_W-1:0]];

  // Pointer advance; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (IDX_W+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (IDX_W+1)'(1);
    end
  end

  // Packet storage; contents only matter while covered by the pointers.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[IDX_W-1:0]] <= push_pkt;
  end

  // An entry is live when its distance from the read index is below the count.
  always_comb begin
    ent_write = '0;
    offs      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs         = IDX_W'(i) - rd_ptr[IDX_W-1:0];
      ent_write[i] = ({1'b0, offs} < count) && (mem[i].op == UPD_WRITE);
      ent_set[i]   = mem[i].set[SET_W-1:0];
    end
  end

endmodule

// File: rtl/llc_update_queue.sv
// LLC update stage: queues update packets and drains them to the SRAM write
// ports, running reset/flush as multi-cycle sweeps over every set.
module llc_update_queue
  import llc_update_queue_pkg::*;
#(
  parameter  int unsigned WAYS  = LLC_WAYS,
  parameter  int unsigned SETS  = LLC_SETS,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  llc_upd_pkt_t     in_pkt,
  output logic             wr_en,
  output logic [SET_W-1:0] wr_set,
  output llc_way_t         wr_way,
  output llc_entry_t       wr_entry,
  output logic             wr_en_evict_way,
  output llc_way_t         wr_evict_way,
  output logic [WAYS-1:0]  wr_rst_flush,
  output logic             rd_en,
  output logic [SET_W-1:0] rd_set,
  input  llc_state_t       rd_states [WAYS],
  input  llc_hprot_t       rd_hprots [WAYS],
  input  logic [SET_W-1:0] lookup_set,
  output logic             lookup_hazard,
  output logic             sweep_busy,
  output logic             done_valid,
  input  logic             done_ready
);

  llc_upd_state_t   state;
  logic [SET_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head_pass;
  logic             last_set;
  logic             queued_hit;
  llc_upd_pkt_t     head;
  logic [DEPTH-1:0] ent_write;
  logic [SET_W-1:0] ent_set [DEPTH];

  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign last_set = (cnt == SET_W'(SETS - 1));

  // Any non-sweep head retires straight from IDLE; unknown ops drop silently.
  assign head_pass = !rst && (state == IDLE) && !empty &&
                     (head.op != UPD_RST) && (head.op != UPD_FLUSH);
  assign pop       = head_pass || (!rst && (state == DONE) && done_ready);

  llc_update_fifo #(
    .DEPTH (DEPTH),
    .SET_W (SET_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pkt  (in_pkt),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .ent_write (ent_write),
    .ent_set   (ent_set)
  );

  // Sweep sequencer: launches from a sweep packet at the head, walks every set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty && head.op == UPD_RST) begin
            cnt   <= '0;
            state <= RST_SWEEP;
          end else if (!empty && head.op == UPD_FLUSH) begin
            cnt   <= '0;
            state <= FLUSH_RD;
          end
        end
        RST_SWEEP: begin
          if (last_set) state <= DONE;
          else          cnt   <= cnt + SET_W'(1);
        end
        FLUSH_RD: state <= FLUSH_WR;
        FLUSH_WR: begin
          if (last_set) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + SET_W'(1);
            state <= FLUSH_RD;
          end
        end
        DONE: begin
          if (done_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write/read port mux; everything idles at zero, and reset silences it at once.
  always_comb begin
    wr_en           = 1'b0;
    wr_set          = '0;
    wr_way          = '0;
    wr_entry        = '0;
    wr_en_evict_way = 1'b0;
    wr_evict_way    = '0;
    wr_rst_flush    = '0;
    rd_en           = 1'b0;
    rd_set          = '0;
    done_valid      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (head_pass && head.op == UPD_WRITE) begin
            wr_en           = 1'b1;
            wr_set          = head.set[SET_W-1:0];
            wr_way          = head.way;
            wr_entry        = head.entry;
            wr_en_evict_way = head.upd_evict;
            wr_evict_way    = head.evict_way;
          end
        end
        RST_SWEEP: begin
          wr_rst_flush    = '1;
          wr_set          = cnt;
          wr_entry.state  = INVALID;
          wr_en_evict_way = 1'b1;
        end
        FLUSH_RD: begin
          rd_en  = 1'b1;
          rd_set = cnt;
        end
        FLUSH_WR: begin
          wr_set         = cnt;
          wr_entry.state = INVALID;
          for (int unsigned w = 0; w < WAYS; w++)
            wr_rst_flush[w] = is_flushable(rd_states[w], rd_hprots[w]);
        end
        DONE: done_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Same-set hazard against every live queued write.
  always_comb begin
    queued_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (ent_write[i] && ent_set[i] == lookup_set)
        queued_hit = 1'b1;
  end

  assign sweep_busy    = !rst && (state != IDLE);
  assign lookup_hazard = !rst && (sweep_busy || queued_hit);

endmodule

// File: tb/tb_llc_update_queue.sv
// Directed bench for llc_update_queue with a queue/age-based reference model.
module tb_llc_update_queue;
  import llc_update_queue_pkg::*;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned SETS  = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SET_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  llc_upd_pkt_t     in_pkt = '0;
  logic             wr_en;
  logic [SET_W-1:0] wr_set;
  llc_way_t         wr_way;
  llc_entry_t       wr_entry;
  logic             wr_en_evict_way;
  llc_way_t         wr_evict_way;
  logic [WAYS-1:0]  wr_rst_flush;
  logic             rd_en;
  logic [SET_W-1:0] rd_set;
  llc_state_t       rd_states [WAYS];
  llc_hprot_t       rd_hprots [WAYS];
  logic [SET_W-1:0] lookup_set = '0;
  logic             lookup_hazard;
  logic             sweep_busy;
  logic             done_valid;
  logic             done_ready = 1'b0;

  llc_update_queue #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pkt          (in_pkt),
    .wr_en           (wr_en),
    .wr_set          (wr_set),
    .wr_way          (wr_way),
    .wr_entry        (wr_entry),
    .wr_en_evict_way (wr_en_evict_way),
    .wr_evict_way    (wr_evict_way),
    .wr_rst_flush    (wr_rst_flush),
    .rd_en           (rd_en),
    .rd_set          (rd_set),
    .rd_states       (rd_states),
    .rd_hprots       (rd_hprots),
    .lookup_set      (lookup_set),
    .lookup_hazard   (lookup_hazard),
    .sweep_busy      (sweep_busy),
    .done_valid      (done_valid),
    .done_ready      (done_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The queue holds packets in order; a sweep packet at the head ages by one
  // per cycle: age 0 is its launch, ages 1..L do the work, beyond L it waits
  // for the done handshake. L = SETS for reset, 2*SETS for flush (read then
  // write per set).
  llc_upd_pkt_t mq[$];
  int           age      = 0;
  bit           m_pushed = 1'b0;

  task automatic model_step();
    logic             e_ready, e_wr_en, e_ev_en, e_rd_en, e_busy, e_done, e_haz;
    logic [SET_W-1:0] e_wr_set, e_rd_set;
    llc_way_t         e_way, e_ev_way;
    llc_entry_t       e_entry;
    logic [WAYS-1:0]  e_flush;
    llc_upd_pkt_t     h;
    bit               do_pop;
    int               len, j;
    e_ready = 0; e_wr_en = 0; e_ev_en = 0; e_rd_en = 0; e_busy = 0; e_done = 0; e_haz = 0;
    e_wr_set = '0; e_rd_set = '0; e_way = '0; e_ev_way = '0; e_entry = '0; e_flush = '0;
    do_pop = 0;
    m_pushed = 0;
    if (!rst) begin
      e_ready = (mq.size() < DEPTH);
      if (mq.size() > 0) begin
        h = mq[0];
        if (h.op == UPD_WRITE) begin
          e_wr_en  = 1;
          e_wr_set = h.set[SET_W-1:0];
          e_way    = h.way;
          e_entry  = h.entry;
          e_ev_en  = h.upd_evict;
          e_ev_way = h.evict_way;
          do_pop   = 1;
        end else begin
          len    = (h.op == UPD_RST) ? SETS : 2 * SETS;
          e_busy = (age >= 1);
          if (age >= 1 && age <= len) begin
            j = age - 1;
            if (h.op == UPD_RST) begin
              e_flush  = '1;
              e_wr_set = SET_W'(j);
              e_ev_en  = 1;
            end else if (j % 2 == 0) begin
              e_rd_en  = 1;
              e_rd_set = SET_W'(j / 2);
            end else begin
              e_wr_set = SET_W'(j / 2);
              for (int w = 0; w < WAYS; w++)
                e_flush[w] = (rd_states[w] == VALID) && (rd_hprots[w] == DATA);
            end
          end else if (age > len) begin
            e_done = 1;
            do_pop = done_ready;
          end
        end
      end
      e_haz = e_busy;
      foreach (mq[i])
        if (mq[i].op == UPD_WRITE && mq[i].set[SET_W-1:0] == lookup_set)
          e_haz = 1;
    end

    chk("in_ready",        128'(in_ready),        128'(e_ready));
    chk("wr_en",           128'(wr_en),           128'(e_wr_en));
    chk("wr_set",          128'(wr_set),          128'(e_wr_set));
    chk("wr_way",          128'(wr_way),          128'(e_way));
    chk("wr_entry",        128'(wr_entry),        128'(e_entry));
    chk("wr_en_evict_way", 128'(wr_en_evict_way), 128'(e_ev_en));
    chk("wr_evict_way",    128'(wr_evict_way),    128'(e_ev_way));
    chk("wr_rst_flush",    128'(wr_rst_flush),    128'(e_flush));
    chk("rd_en",           128'(rd_en),           128'(e_rd_en));
    chk("rd_set",          128'(rd_set),          128'(e_rd_set));
    chk("lookup_hazard",   128'(lookup_hazard),   128'(e_haz));
    chk("sweep_busy",      128'(sweep_busy),      128'(e_busy));
    chk("done_valid",      128'(done_valid),      128'(e_done));

    if (rst) begin
      mq.delete();
      age = 0;
    end else begin
      if (do_pop) begin
        void'(mq.pop_front());
        age = 0;
      end else if (mq.size() > 0 && mq[0].op != UPD_WRITE) begin
        age++;
      end
      if (in_valid && e_ready) begin
        mq.push_back(in_pkt);
        m_pushed = 1;
      end
    end
  endtask

  // Compare process: checks every cycle at the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic llc_upd_pkt_t mk(input llc_upd_op_t op, input int unsigned s,
                                      input int unsigned w, input logic [15:0] tag,
                                      input int unsigned ev, input logic upd_ev);
    llc_upd_pkt_t p;
    p               = '0;
    p.op            = op;
    p.set           = llc_set_t'(s);
    p.way           = llc_way_t'(w);
    p.entry.tag     = tag;
    p.entry.state   = VALID;
    p.entry.line    = {tag, ~tag};
    p.entry.hprot   = DATA;
    p.entry.owner   = 4'(w);
    p.entry.sharers = 16'(1) << w;
    p.entry.dirty   = 1'b1;
    p.evict_way     = llc_way_t'(ev);
    p.upd_evict     = upd_ev;
    return p;
  endfunction

  task automatic push(input llc_upd_pkt_t p);
    in_valid = 1'b1;
    in_pkt   = p;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (m_pushed) break;
    end
    chk("push_accepted", 128'(m_pushed), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (done_valid) break;
      tick();
    end
    chk("done_reached", 128'(done_valid), 128'(1));
  endtask

  llc_upd_pkt_t w0, w1, w2, wa, wb, wc, wd, wx;

  initial begin
    for (int w = 0; w < WAYS; w++) begin
      rd_states[w] = INVALID;
      rd_hprots[w] = 1'b0;
    end
    w0 = mk(UPD_WRITE, 5, 2, 16'hA001, 7, 1'b1);
    w1 = mk(UPD_WRITE, 5, 3, 16'hA002, 0, 1'b0);
    w2 = mk(UPD_WRITE, 9, 0, 16'hA003, 1, 1'b1);
    wa = mk(UPD_WRITE, 1, 4, 16'hB001, 2, 1'b1);
    wb = mk(UPD_WRITE, 2, 5, 16'hB002, 3, 1'b0);
    wc = mk(UPD_WRITE, 3, 6, 16'hB003, 4, 1'b1);
    wd = mk(UPD_WRITE, 4, 7, 16'hB004, 5, 1'b0);
    wx = mk(UPD_WRITE, 7, 1, 16'hC001, 6, 1'b1);

    // reset state
    repeat (3) tick();
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_wr_en",    128'(wr_en),    128'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 128'(in_ready),   128'(1));
    chk("idle_busy",       128'(sweep_busy), 128'(0));

    // three back-to-back writes, hazard on set 5
    lookup_set = 4'd5;
    in_valid   = 1'b1;
    in_pkt     = w0;
    #1;
    chk("haz_empty", 128'(lookup_hazard), 128'(0));
    tick();
    in_pkt = w1;
    #1;
    chk("w0_en",    128'(wr_en),         128'(1));
    chk("w0_set",   128'(wr_set),        128'(5));
    chk("w0_way",   128'(wr_way),        128'(2));
    chk("w0_entry", 128'(wr_entry),      128'(w0.entry));
    chk("w0_haz",   128'(lookup_hazard), 128'(1));
    tick();
    in_pkt = w2;
    #1;
    chk("w1_way",   128'(wr_way),          128'(3));
    chk("w1_ev_en", 128'(wr_en_evict_way), 128'(0));
    chk("w1_haz",   128'(lookup_hazard),   128'(1));
    tick();
    in_valid = 1'b0;
    #1;
    chk("w2_set", 128'(wr_set),        128'(9));
    chk("w2_haz", 128'(lookup_hazard), 128'(0));
    tick();
    #1;
    chk("drained_wr_en", 128'(wr_en), 128'(0));

    // reset sweep, done held three cycles
    push(mk(UPD_RST, 3, 3, 16'hFFFF, 3, 1'b1));
    #1;
    chk("rst_launch_busy", 128'(sweep_busy), 128'(0));
    tick();
    for (int i = 0; i < SETS; i++) begin
      #1;
      chk("rsw_flush", 128'(wr_rst_flush),    128'(4'hF));
      chk("rsw_set",   128'(wr_set),          128'(i));
      chk("rsw_ev_en", 128'(wr_en_evict_way), 128'(1));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      done_ready = (k == 2);
      #1;
      chk("rst_done_held", 128'(done_valid), 128'(1));
      tick();
    end
    done_ready = 1'b0;
    #1;
    chk("rst_done_clear", 128'(done_valid), 128'(0));
    tick();

    // flush sweep: valid on ways 1,3; data only on way 1
    rd_states[0] = 3'd2;
    rd_states[1] = VALID;
    rd_states[3] = VALID;
    rd_hprots[1] = DATA;
    push(mk(UPD_FLUSH, 0, 0, 16'h1234, 0, 1'b0));
    tick();
    for (int s = 0; s < SETS; s++) begin
      #1;
      chk("fl_rd_en",  128'(rd_en),  128'(1));
      chk("fl_rd_set", 128'(rd_set), 128'(s));
      tick();
      #1;
      chk("fl_mask",   128'(wr_rst_flush), 128'(4'b0010));
      chk("fl_wr_set", 128'(wr_set),       128'(s));
      tick();
    end
    done_ready = 1'b1;
    #1;
    chk("fl_done", 128'(done_valid), 128'(1));
    tick();
    done_ready = 1'b0;
    #1;
    chk("fl_done_clear", 128'(done_valid), 128'(0));
    tick();

    // full queue behind a reset sweep
    push(mk(UPD_RST, 0, 0, 16'h0, 0, 1'b0));
    push(wa);
    push(wb);
    push(wc);
    lookup_set = 4'd3;
    in_valid   = 1'b1;
    in_pkt     = wd;
    #1;
    chk("full_ready", 128'(in_ready), 128'(0));
    wait_done();
    done_ready = 1'b1;
    #1;
    chk("full_pop_ready", 128'(in_ready), 128'(0));
    tick();
    done_ready = 1'b0;
    #1;
    chk("after_pop_ready", 128'(in_ready), 128'(1));
    chk("drain_a_en",      128'(wr_en),    128'(1));
    chk("drain_a_way",     128'(wr_way),   128'(4));
    tick();
    in_valid = 1'b0;
    repeat (5) tick();

    // reset in the middle of a flush sweep
    push(mk(UPD_FLUSH, 0, 0, 16'h0, 0, 1'b0));
    push(wx);
    lookup_set = 4'd7;
    done_ready = 1'b1;
    repeat (6) tick();
    #1;
    chk("mid_flush_busy", 128'(sweep_busy), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_rd_en", 128'(rd_en),         128'(0));
    chk("abort_flush", 128'(wr_rst_flush),  128'(0));
    chk("abort_busy",  128'(sweep_busy),    128'(0));
    chk("abort_ready", 128'(in_ready),      128'(1));
    chk("abort_haz",   128'(lookup_hazard), 128'(0));
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("abort_no_done", 128'(done_valid), 128'(0));
    end
    done_ready = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
